// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-port bundle shared by the data-memory arbiter
// and its requesters. Signal names follow the memory-side naming of the datapath.
interface dmem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [1:0]               req_we;
  logic [1:0]               req_adtp;
  logic [ADDRESS_WIDTH-1:0] req_addr0;
  logic [ADDRESS_WIDTH-1:0] req_addr1;
  logic [DATA_WIDTH-1:0]    req_wdata0;
  logic [DATA_WIDTH-1:0]    req_wdata1;

  logic [1:0]               rsp_valid;
  logic                     rsp_err;
  logic [DATA_WIDTH-1:0]    rsp_rdata;

  logic [ADDRESS_WIDTH-1:0] mem_A;
  logic [DATA_WIDTH-1:0]    mem_WD;
  logic                     mem_WE;
  logic                     mem_ADTP;
  logic [DATA_WIDTH-1:0]    mem_RD;

  modport slave (
    input  req_valid, req_we, req_adtp, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_RD,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_A, mem_WD, mem_WE, mem_ADTP
  );

  modport master (
    output req_valid, req_we, req_adtp, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_RD,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_A, mem_WD, mem_WE, mem_ADTP
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one data-memory port between
// the CPU load/store path (requester 0) and the loader/debug port (requester 1).
module dmem_arbiter #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_TOP       = ADDRESS_WIDTH'(32'h1FFFF)
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;

  logic                     r_lastGrant;
  logic                     r_id;
  logic                     r_we;
  logic                     r_adtp;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_rspErr;
  logic [DATA_WIDTH-1:0]    r_rspRdata;

  logic                     w_accept;
  logic                     w_grantId;
  logic [ADDRESS_WIDTH:0]   w_lastByte;
  logic                     w_rangeErr;
  logic [DATA_WIDTH-1:0]    w_readData;

  // One extra bit on the last-byte address so a word access near the top of
  // the address space cannot wrap around and slip past the range check.
  assign w_lastByte = {1'b0, r_addr} + (ADDRESS_WIDTH+1)'(3);
  assign w_rangeErr = (r_addr > MEM_TOP) || (!r_adtp && (w_lastByte > {1'b0, MEM_TOP}));
  assign w_readData = r_adtp ? {{(DATA_WIDTH-8){1'b0}}, bus.mem_RD[7:0]} : bus.mem_RD;

  assign bus.rsp_err   = r_rspErr;
  assign bus.rsp_rdata = r_rspRdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_accept      = 1'b0;
    w_grantId     = r_lastGrant;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.mem_A     = '0;
    bus.mem_WD    = '0;
    bus.mem_WE    = 1'b0;
    bus.mem_ADTP  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|bus.req_valid) begin
          w_accept      = 1'b1;
          w_grantId     = (&bus.req_valid) ? ~r_lastGrant : ~bus.req_valid[0];
          bus.req_ready = w_grantId ? 2'b10 : 2'b01;
          w_nextState   = ACCESS;
        end
      end
      ACCESS: begin
        if (!w_rangeErr) begin
          bus.mem_A    = r_addr;
          bus.mem_WD   = r_wdata;
          bus.mem_WE   = r_we;
          bus.mem_ADTP = r_adtp;
        end
        w_nextState = RESP;
      end
      RESP: begin
        bus.rsp_valid = r_id ? 2'b10 : 2'b01;
        w_nextState   = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Payload is sampled only at accept; the response registers are loaded at
  // the edge that ends ACCESS, which is also when the memory write commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant <= 1'b1;
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_adtp      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rspErr    <= 1'b0;
      r_rspRdata  <= '0;
    end else begin
      if (w_accept) begin
        r_id        <= w_grantId;
        r_lastGrant <= w_grantId;
        r_we        <= bus.req_we[w_grantId];
        r_adtp      <= bus.req_adtp[w_grantId];
        r_addr      <= w_grantId ? bus.req_addr1 : bus.req_addr0;
        r_wdata     <= w_grantId ? bus.req_wdata1 : bus.req_wdata0;
      end
      if (r_state == ACCESS) begin
        r_rspErr   <= w_rangeErr;
        r_rspRdata <= (w_rangeErr || r_we) ? '0 : w_readData;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-addressed little-endian memory model,
// hand-computed expectations checked with immediate assertions.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cycleCount = 0;
  int   prevCycle = 0;

  logic [7:0] memArr [0:131071] = '{default: 8'h00};

  dmem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .MEM_TOP      (32'h1FFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Memory model: byte lanes are little-endian, word accesses may be misaligned.
  always @(posedge clk) begin
    if (bus.mem_WE) begin
      if (bus.mem_ADTP) begin
        memArr[bus.mem_A[16:0]] <= bus.mem_WD[7:0];
      end else begin
        for (int i = 0; i < 4; i++) begin
          memArr[17'(bus.mem_A[16:0] + 17'(i))] <= bus.mem_WD[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    if (bus.mem_ADTP) begin
      bus.mem_RD = {24'h0, memArr[bus.mem_A[16:0]]};
    end else begin
      bus.mem_RD = {memArr[17'(bus.mem_A[16:0] + 17'd3)], memArr[17'(bus.mem_A[16:0] + 17'd2)],
                    memArr[17'(bus.mem_A[16:0] + 17'd1)], memArr[bus.mem_A[16:0]]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic valid, input logic we, input logic adtp,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid[id] = valid;
    bus.req_we[id]    = we;
    bus.req_adtp[id]  = adtp;
    if (id == 0) begin
      bus.req_addr0  = addr;
      bus.req_wdata0 = wdata;
    end else begin
      bus.req_addr1  = addr;
      bus.req_wdata1 = wdata;
    end
  endtask

  task automatic waitReady(input int id);
    int n = 0;
    #1;
    while (!bus.req_ready[id] && n < 20) begin
      tick();
      n++;
    end
    checkOutput("ready wait", {31'b0, bus.req_ready[id]}, 32'd1);
  endtask

  // Full transaction: accept, ACCESS cycle, RESP cycle, back to IDLE.
  task automatic runTxn(input string tag, input int id, input logic we, input logic adtp,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic expErr, input logic [31:0] expRdata);
    applyStimulus(id, 1'b1, we, adtp, addr, wdata);
    waitReady(id);
    tick();
    applyStimulus(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, " mem_WE"}, {31'b0, bus.mem_WE}, expErr ? 32'd0 : {31'b0, we});
    checkOutput({tag, " mem_A"}, bus.mem_A, expErr ? 32'd0 : addr);
    checkOutput({tag, " rsp_valid access"}, {30'b0, bus.rsp_valid}, 32'd0);
    tick();
    checkOutput({tag, " rsp_valid"}, {30'b0, bus.rsp_valid}, (id == 1) ? 32'd2 : 32'd1);
    checkOutput({tag, " rsp_err"}, {31'b0, bus.rsp_err}, {31'b0, expErr});
    checkOutput({tag, " rsp_rdata"}, bus.rsp_rdata, expRdata);
    checkOutput({tag, " mem_WE resp"}, {31'b0, bus.mem_WE}, 32'd0);
    tick();
    checkOutput({tag, " rsp_valid idle"}, {30'b0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_we     = 2'b00;
    bus.req_adtp   = 2'b00;
    bus.req_addr0  = '0;
    bus.req_addr1  = '0;
    bus.req_wdata0 = '0;
    bus.req_wdata1 = '0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    checkOutput("reset rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset mem_A", bus.mem_A, 32'd0);
    checkOutput("reset mem_WE", {31'b0, bus.mem_WE}, 32'd0);
    checkOutput("reset req_ready", {30'b0, bus.req_ready}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    runTxn("wr word 100", 0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
    runTxn("rd word 100", 0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF);
    runTxn("rd byte 101", 0, 1'b0, 1'b1, 32'h101, 32'h0, 1'b0, 32'h000000BE);
    runTxn("wr byte 103", 0, 1'b1, 1'b1, 32'h103, 32'h11, 1'b0, 32'h0);
    runTxn("rd word 100b", 0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h11ADBEEF);

    runTxn("rd word 1FFFD", 0, 1'b0, 1'b0, 32'h1FFFD, 32'h0, 1'b1, 32'h0);
    runTxn("wr word 1FFFE", 1, 1'b1, 1'b0, 32'h1FFFE, 32'hFFFFFFFF, 1'b1, 32'h0);
    runTxn("rd byte 1FFFF", 0, 1'b0, 1'b1, 32'h1FFFF, 32'h0, 1'b0, 32'h0);
    runTxn("rd word FFFFFFFE", 1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b1, 32'h0);
    checkOutput("mem 1FFFE untouched", {24'h0, memArr[17'h1FFFE]}, 32'h0);

    // Reset in the middle of a write's ACCESS cycle; request stays held.
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h55);
    waitReady(0);
    tick();
    checkOutput("rstacc mem_WE before", {31'b0, bus.mem_WE}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstacc mem_WE async", {31'b0, bus.mem_WE}, 32'd0);
    checkOutput("rstacc mem_A async", bus.mem_A, 32'd0);
    tick();
    checkOutput("rstacc mem 10", {24'h0, memArr[17'h10]}, 32'h0);
    checkOutput("rstacc rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    tick();
    checkOutput("rstacc rsp_valid 2", {30'b0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rstacc ready after", {30'b0, bus.req_ready}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("rstacc retry rsp", {30'b0, bus.rsp_valid}, 32'd1);
    tick();
    checkOutput("rstacc mem 10 written", {24'h0, memArr[17'h10]}, 32'h55);

    // Requester 1 raises valid while requester 0 is in flight.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    waitReady(0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h400, 32'hCAFEF00D);
    #1;
    checkOutput("held ready access", {30'b0, bus.req_ready}, 32'd0);
    tick();
    checkOutput("held ready resp", {30'b0, bus.req_ready}, 32'd0);
    checkOutput("held r0 rsp_valid", {30'b0, bus.rsp_valid}, 32'd1);
    checkOutput("held r0 rdata", bus.rsp_rdata, 32'h11ADBEEF);
    tick();
    checkOutput("held ready idle", {30'b0, bus.req_ready}, 32'd2);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("held mem_A", bus.mem_A, 32'h400);
    checkOutput("held mem_WD", bus.mem_WD, 32'hCAFEF00D);
    checkOutput("held mem_WE", {31'b0, bus.mem_WE}, 32'd1);
    tick();
    checkOutput("held r1 rsp_valid", {30'b0, bus.rsp_valid}, 32'd2);
    tick();
    runTxn("rd word 400", 0, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 32'hCAFEF00D);

    // Continuous dual load from reset: alternating grants, 3 cycles apart.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0);
    #1;
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      while (bus.req_ready == 2'b00 && n < 20) begin
        tick();
        n++;
      end
      checkOutput("rr grant", {30'b0, bus.req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) checkOutput("rr spacing", cycleCount - prevCycle, 32'd3);
      prevCycle = cycleCount;
      tick();
    end
    bus.req_valid = 2'b00;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
